// File: rtl/nexusv_prefetch_unit_pkg.sv
// Shared constants for the nexusV instruction front-end: word width, fetch entry
// width and the RV32I NOP encoding.
package nexusv_prefetch_unit_pkg;

   localparam int unsigned RV_XLEN       = 32;
   localparam int unsigned FETCH_ENTRY_W = RV_XLEN + 32;
   localparam logic [31:0] RV_NOP        = 32'h0000_0013;

   function automatic logic [RV_XLEN-1:0] next_word_addr(input logic [RV_XLEN-1:0] addr);
      return addr + RV_XLEN'(4);
   endfunction

endpackage

// File: rtl/nexusv_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a zero-filled head when empty.
// Push and pop in the same cycle are accepted even when full.
module nexusv_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries data only, so it is never reset.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/nexusv_prefetch_unit.sv
// nexusV prefetch unit: credit-gated imem requester, in-order response queue and
// single-cycle redirect flush. Optional counters under NEXUSV_FETCH_PERF_EN.
module nexusv_prefetch_unit
   import nexusv_prefetch_unit_pkg::*;
#(
   parameter int               XLEN     = RV_XLEN,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_data,
   output logic [XLEN-1:0] instr_pc
`ifdef NEXUSV_FETCH_PERF_EN
   ,
   output logic [31:0]     perf_stall_cnt,
   output logic [15:0]     perf_flush_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 2;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] pc_tag;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_nxt;
   logic [CW-1:0]   discard_cnt;
   logic [CW-2:0]   occ;
   logic            fifo_full;
   logic            fifo_empty;
   logic            credit_ok;
   logic            req_fire;
   logic            rsp_drop;
   logic            push;
   logic            pop;

   // Every in-flight request already owns a queue slot, so responses never overflow.
   assign credit_ok       = ~fifo_full & ((CW'(occ) + outstanding) < CW'(DEPTH));
   assign imem_req_valid  = credit_ok & ~redirect_valid & ~rst;
   assign imem_req_addr   = fetch_pc;
   assign req_fire        = imem_req_valid & imem_req_ready;
   assign rsp_drop        = redirect_valid | (discard_cnt != '0);
   assign push            = imem_rsp_valid & ~rsp_drop;
   assign pop             = instr_valid & instr_ready;
   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
   assign instr_valid     = ~fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         pc_tag      <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            // Whatever is still in flight after this cycle belongs to the old path.
            fetch_pc    <= redirect_pc;
            pc_tag      <= redirect_pc;
            discard_cnt <= outstanding_nxt;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (imem_rsp_valid) begin
               if (discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
               else                   pc_tag      <= pc_tag + XLEN'(4);
            end
         end
      end
   end

   nexusv_sync_fifo #(
      .WIDTH (XLEN + 32),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({pc_tag, imem_rsp_data}),
      .head  ({instr_pc, instr_data}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

`ifdef NEXUSV_FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (instr_ready && !instr_valid && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_valid && (perf_flush_cnt != '1))
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nexusv_prefetch_unit.sv
// Directed bench for nexusv_prefetch_unit with a fixed-latency in-order memory
// model returning ~addr as the instruction word.
module tb_nexusv_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
`ifdef NEXUSV_FETCH_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
`endif

   nexusv_prefetch_unit #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc)
`ifdef NEXUSV_FETCH_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          n_req = 0;
   int          n_deliv = 0;
   logic [31:0] last_pc = '0;
   logic        drv_rst = 1'b1;
   logic        drv_redirect = 1'b0;
   logic        drv_ready = 1'b0;
   logic [31:0] drv_redirect_pc = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: apply inputs on the falling edge, settle, then log handshakes
   // that will complete on the next rising edge.
   task automatic cycle();
      @(negedge clk);
      cyc++;
      rst            = drv_rst;
      redirect_valid = drv_redirect;
      redirect_pc    = drv_redirect_pc;
      instr_ready    = drv_ready;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (drv_rst) begin
         pend.delete();
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = ~pend[0].addr;
         void'(pend.pop_front());
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         pend.push_back('{addr: imem_req_addr, due: cyc + lat});
         n_req++;
      end
      if (instr_valid && instr_ready) begin
         n_deliv++;
         last_pc = instr_pc;
      end
   endtask

   task automatic do_reset(input int l);
      drv_rst      = 1'b1;
      drv_redirect = 1'b0;
      drv_ready    = 1'b0;
      lat          = l;
      cycle();
      cycle();
      drv_rst = 1'b0;
      n_req   = 0;
      n_deliv = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;

      // Reset state
      do_reset(1);
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr_data", instr_data, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_fetch_pc", dut.fetch_pc, 32'h0);

      // Streaming, L=1
      drv_ready = 1'b1;
      cycle();
      chk("s_req0_valid", imem_req_valid, 1'b1);
      chk("s_req0_addr", imem_req_addr, 32'h0);
      chk("s_c0_ivalid", instr_valid, 1'b0);
      cycle();
      chk("s_req1_addr", imem_req_addr, 32'h4);
      chk("s_c1_ivalid", instr_valid, 1'b0);
      cycle();
      chk("s_c2_ivalid", instr_valid, 1'b1);
      chk("s_c2_pc", instr_pc, 32'h0);
      chk("s_c2_data", instr_data, 32'hFFFF_FFFF);
      chk("s_req2_addr", imem_req_addr, 32'h8);
      cycle();
      chk("s_c3_pc", instr_pc, 32'h4);
      chk("s_c3_data", instr_data, 32'hFFFF_FFFB);

      // Backpressure fills the queue and stops requests
      do_reset(1);
      repeat (8) cycle();
      chk("bp_nreq", n_req, 4);
      chk("bp_req_valid", imem_req_valid, 1'b0);
      chk("bp_head_pc", instr_pc, 32'h0);
      drv_ready = 1'b1;
      cycle();
      chk("bp_pop_req_valid", imem_req_valid, 1'b0);
      drv_ready = 1'b0;
      cycle();
      chk("bp_refill_valid", imem_req_valid, 1'b1);
      chk("bp_refill_addr", imem_req_addr, 32'h10);
      chk("bp_head_pc2", instr_pc, 32'h4);
      repeat (4) cycle();
      chk("bp_nreq2", n_req, 5);
      chk("bp_req_valid2", imem_req_valid, 1'b0);

      // L=3, redirect with three stale requests in flight
      do_reset(3);
      drv_ready = 1'b1;
      repeat (3) cycle();
      drv_redirect    = 1'b1;
      drv_redirect_pc = 32'h0000_0100;
      cycle();
      chk("r3_rsp_in_redirect", imem_rsp_valid, 1'b1);
      chk("r3_req_blocked", imem_req_valid, 1'b0);
      drv_redirect = 1'b0;
      cycle();
      chk("r3_ivalid_after", instr_valid, 1'b0);
      chk("r3_new_req_valid", imem_req_valid, 1'b1);
      chk("r3_new_req_addr", imem_req_addr, 32'h0000_0100);
      chk("r3_discard", dut.discard_cnt, 32'd2);
      for (int i = 0; i < 20 && !instr_valid; i++) cycle();
      chk("r3_first_valid", instr_valid, 1'b1);
      chk("r3_first_pc", instr_pc, 32'h0000_0100);
      chk("r3_first_data", instr_data, 32'hFFFF_FEFF);
      chk("r3_ndeliv", n_deliv, 1);

      // Redirect coincident with a response and an instr handshake, L=2
      do_reset(2);
      drv_ready = 1'b1;
      repeat (4) cycle();
      chk("rc_pre_pc", instr_pc, 32'h0);
      drv_redirect    = 1'b1;
      drv_redirect_pc = 32'h0000_0200;
      cycle();
      chk("rc_rsp_coincident", imem_rsp_valid, 1'b1);
      chk("rc_taken_pc", last_pc, 32'h4);
      drv_redirect = 1'b0;
      cycle();
      chk("rc_ivalid_after", instr_valid, 1'b0);
      chk("rc_discard", dut.discard_cnt, 32'd1);
      for (int i = 0; i < 20 && !instr_valid; i++) cycle();
      chk("rc_first_pc", instr_pc, 32'h0000_0200);
      chk("rc_first_data", instr_data, 32'hFFFF_FDFF);
      chk("rc_ndeliv", n_deliv, 3);

      // Fetch address wrap
      do_reset(1);
      drv_ready       = 1'b1;
      drv_redirect    = 1'b1;
      drv_redirect_pc = 32'hFFFF_FFFC;
      cycle();
      drv_redirect = 1'b0;
      cycle();
      chk("w_req_top", imem_req_addr, 32'hFFFF_FFFC);
      cycle();
      chk("w_req_wrap", imem_req_addr, 32'h0000_0000);
      cycle();
      chk("w_pc_top", instr_pc, 32'hFFFF_FFFC);
      chk("w_data_top", instr_data, 32'h0000_0003);
      cycle();
      chk("w_pc_wrap", instr_pc, 32'h0000_0000);
      chk("w_data_wrap", instr_data, 32'hFFFF_FFFF);

`ifdef NEXUSV_FETCH_PERF_EN
      // Five starved cycles then two redirects
      do_reset(4);
      chk("p_rst_stall", perf_stall_cnt, 32'd0);
      chk("p_rst_flush", {16'h0, perf_flush_cnt}, 32'd0);
      drv_ready = 1'b1;
      repeat (5) cycle();
      drv_ready = 1'b0;
      cycle();
      chk("p_first_valid", instr_valid, 1'b1);
      drv_redirect    = 1'b1;
      drv_redirect_pc = 32'h0000_0040;
      cycle();
      drv_redirect = 1'b0;
      cycle();
      drv_redirect = 1'b1;
      cycle();
      drv_redirect = 1'b0;
      cycle();
      chk("p_stall_cnt", perf_stall_cnt, 32'd5);
      chk("p_flush_cnt", {16'h0, perf_flush_cnt}, 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
